// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch: PC owner, memory requester, decode handshake, redirect squash.
// Latency: word valid the cycle after memValid; no prefetch. Backpressure: HOLD keeps the word until instructionAccept.
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] memAddress,
    output logic        memRequest,
    input  logic        memValid,
    input  logic [31:0] memData,
    output logic [31:0] instructionData,
    output logic        instructionValid,
    input  logic        instructionAccept,
    output logic [31:0] pcOut,
    output logic [31:0] nextPcAddress,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic        addressError
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcout_q, pcout_d;
    logic        squash_q, squash_d;
    logic        gap_q, gap_d;
    logic        aerr_q, aerr_d;

    logic [31:0] target_al;
    logic        req_done;
    logic        req_wait;

    assign target_al  = {branchTarget[31:2], 2'b00};
    // gap_q forces the one idle request cycle after a discarded response
    assign memRequest = (state_q == FETCH) && !gap_q;
    assign req_done   = memRequest && memValid;
    assign req_wait   = memRequest && !memValid;

    assign memAddress       = addr_q;
    assign instructionValid = (state_q == HOLD);
    assign instructionData  = (state_q == HOLD) ? instr_q : NOP_WORD;
    assign pcOut            = pcout_q;
    assign nextPcAddress    = pcout_q + 32'd4;
    assign addressError     = aerr_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pcout_d  = pcout_q;
        squash_d = squash_q;
        gap_d    = 1'b0;
        aerr_d   = branchTaken && (state_q != IDLE) && (branchTarget[1:0] != 2'b00);

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (branchTaken) begin
                    pc_d = target_al;
                    if (req_done) begin
                        squash_d = 1'b0;
                        gap_d    = 1'b1;
                    end else if (req_wait) begin
                        squash_d = 1'b1;
                    end
                end else if (req_done) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        gap_d    = 1'b1;
                    end else begin
                        instr_d = memData;
                        pcout_d = pc_q;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (branchTaken) begin
                    pc_d    = target_al;
                    state_d = FETCH;
                end else if (instructionAccept) begin
                    pc_d    = pcout_q + 32'd4;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // the address of an outstanding request never moves; otherwise it tracks the next pc
        addr_d = req_wait ? addr_q : pc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_VECTOR;
            addr_q   <= RESET_VECTOR;
            instr_q  <= NOP_WORD;
            pcout_q  <= RESET_VECTOR;
            squash_q <= 1'b0;
            gap_q    <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            pcout_q  <= pcout_d;
            squash_q <= squash_d;
            gap_q    <= gap_d;
            aerr_q   <= aerr_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a variable-latency instruction memory model.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] memAddress;
    logic        memRequest;
    logic        memValid;
    logic [31:0] memData;
    logic [31:0] instructionData;
    logic        instructionValid;
    logic        instructionAccept;
    logic [31:0] pcOut;
    logic [31:0] nextPcAddress;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        addressError;

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 1;
    int cnt   = 0;

    instruction_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .memAddress       (memAddress),
        .memRequest       (memRequest),
        .memValid         (memValid),
        .memData          (memData),
        .instructionData  (instructionData),
        .instructionValid (instructionValid),
        .instructionAccept(instructionAccept),
        .pcOut            (pcOut),
        .nextPcAddress    (nextPcAddress),
        .branchTaken      (branchTaken),
        .branchTarget     (branchTarget),
        .addressError     (addressError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return a ^ 32'h1357_0000;
    endfunction

    // memory acts on the falling edge; memValid rises lat cycles after the request is seen
    initial begin
        memValid = 1'b0;
        memData  = 32'h0;
        forever begin
            @(negedge clk);
            if (memValid) begin
                memValid = 1'b0;
                cnt = 0;
            end else if (memRequest) begin
                if (cnt == lat) begin
                    memValid = 1'b1;
                    memData  = mem_word(memAddress);
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int bound);
        for (int i = 0; i < bound && instructionValid !== 1'b1; i++) tick();
        chk("wait_valid", {31'd0, instructionValid}, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        instructionAccept = 1'b1;
        branchTaken = 1'b0;
        branchTarget = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {31'd0, memRequest}, 32'd0);
        chk("rst_addr",  memAddress, 32'h0);
        chk("rst_valid", {31'd0, instructionValid}, 32'd0);
        chk("rst_data",  instructionData, 32'h0);
        chk("rst_pc",    pcOut, 32'h0);
        chk("rst_aerr",  {31'd0, addressError}, 32'd0);
        rst = 1'b1;

        // first fetch at the reset vector, accept held high
        tick();
        chk("f0_req",  {31'd0, memRequest}, 32'd1);
        chk("f0_addr", memAddress, 32'h0);
        tick();
        chk("f0_valid_early", {31'd0, instructionValid}, 32'd0);
        tick();
        chk("f0_valid", {31'd0, instructionValid}, 32'd1);
        chk("f0_data",  instructionData, 32'h2008_0005);
        chk("f0_pc",    pcOut, 32'h0);
        chk("f0_npc",   nextPcAddress, 32'h4);
        chk("f0_req_hold", {31'd0, memRequest}, 32'd0);
        tick();
        chk("f1_req",  {31'd0, memRequest}, 32'd1);
        chk("f1_addr", memAddress, 32'h4);
        chk("f1_nop",  instructionData, 32'h0);

        // backpressure in HOLD
        instructionAccept = 1'b0;
        tick();
        tick();
        chk("bp_valid", {31'd0, instructionValid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_data",  instructionData, mem_word(32'h4));
            chk("bp_pc",    pcOut, 32'h4);
            chk("bp_req",   {31'd0, memRequest}, 32'd0);
            chk("bp_valid", {31'd0, instructionValid}, 32'd1);
        end

        // stale response with slow memory
        lat = 4;
        instructionAccept = 1'b1;
        tick();
        instructionAccept = 1'b0;
        chk("st_req",  {31'd0, memRequest}, 32'd1);
        chk("st_addr", memAddress, 32'h8);
        tick();
        tick();
        branchTaken  = 1'b1;
        branchTarget = 32'h100;
        tick();
        branchTaken = 1'b0;
        chk("st_addr_hold", memAddress, 32'h8);
        chk("st_req_hold",  {31'd0, memRequest}, 32'd1);
        chk("st_aerr",      {31'd0, addressError}, 32'd0);
        tick();
        chk("st_addr_hold2", memAddress, 32'h8);
        tick();
        chk("st_gap_req",   {31'd0, memRequest}, 32'd0);
        chk("st_gap_valid", {31'd0, instructionValid}, 32'd0);
        tick();
        chk("st_new_req",  {31'd0, memRequest}, 32'd1);
        chk("st_new_addr", memAddress, 32'h100);
        chk("st_new_valid", {31'd0, instructionValid}, 32'd0);
        wait_valid(20);
        chk("st_pc",   pcOut, 32'h100);
        chk("st_data", instructionData, mem_word(32'h100));
        lat = 1;

        // redirect from HOLD without accept
        branchTaken  = 1'b1;
        branchTarget = 32'h20;
        tick();
        branchTaken = 1'b0;
        chk("hr_valid", {31'd0, instructionValid}, 32'd0);
        chk("hr_nop",   instructionData, 32'h0);
        chk("hr_addr",  memAddress, 32'h20);
        wait_valid(10);
        chk("hr_pc",  pcOut, 32'h20);
        chk("hr_npc", nextPcAddress, 32'h24);

        // redirect and accept together
        instructionAccept = 1'b1;
        branchTaken  = 1'b1;
        branchTarget = 32'h400;
        tick();
        branchTaken = 1'b0;
        instructionAccept = 1'b0;
        chk("ra_addr",  memAddress, 32'h400);
        chk("ra_req",   {31'd0, memRequest}, 32'd1);
        chk("ra_aerr",  {31'd0, addressError}, 32'd0);
        wait_valid(10);
        chk("ra_pc", pcOut, 32'h400);

        // misaligned target
        branchTaken  = 1'b1;
        branchTarget = 32'h103;
        tick();
        branchTaken = 1'b0;
        chk("ma_aerr",  {31'd0, addressError}, 32'd1);
        chk("ma_addr",  memAddress, 32'h100);
        tick();
        chk("ma_aerr_end", {31'd0, addressError}, 32'd0);
        wait_valid(10);
        chk("ma_pc", pcOut, 32'h100);

        // wrap at top of address space
        branchTaken  = 1'b1;
        branchTarget = 32'hFFFF_FFFC;
        tick();
        branchTaken = 1'b0;
        wait_valid(10);
        chk("wr_pc",   pcOut, 32'hFFFF_FFFC);
        chk("wr_npc",  nextPcAddress, 32'h0);
        chk("wr_data", instructionData, mem_word(32'hFFFF_FFFC));
        instructionAccept = 1'b1;
        tick();
        instructionAccept = 1'b0;
        chk("wr_addr", memAddress, 32'h0);
        chk("wr_req",  {31'd0, memRequest}, 32'd1);

        // asynchronous reset mid-fetch
        #2;
        rst = 1'b0;
        #1;
        chk("ar_req",   {31'd0, memRequest}, 32'd0);
        chk("ar_addr",  memAddress, 32'h0);
        chk("ar_valid", {31'd0, instructionValid}, 32'd0);
        chk("ar_data",  instructionData, 32'h0);
        chk("ar_pc",    pcOut, 32'h0);
        chk("ar_npc",   nextPcAddress, 32'h4);
        chk("ar_aerr",  {31'd0, addressError}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
